// File: rtl/fim_dpram_rd_arb.sv
// rtl/fim_dpram_rd_arb.sv - round-robin read arbiter in front of a shared dual-port RAM read port
//
// Purpose: grants one of N_REQ read requesters per cycle onto the RAM read
// port and routes the returning data back to the requester that issued it.
// Responses come back in issue order; there is no response backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_addr  per-requester read request and address slice
//   req_ready           one-hot grant (combinational)
//   ram_r_req/address   read strobe and address to the RAM
//   ram_r_data/valid    read data and valid from the RAM
//   rsp_valid/rsp_data  one-hot return strobe and shared return data
//   err_seq             sticky flag: RAM valid disagreed with issued reads
`timescale 1ns/1ps
module fim_dpram_rd_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DEPTH_LOG2-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        ram_r_req,
  output logic [DEPTH_LOG2-1:0]       ram_r_address,
  input  logic [DATA_WIDTH-1:0]       ram_r_data,
  input  logic                        ram_r_valid,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        err_seq
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MASK_W = $clog2(RD_LATENCY + 1);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [2*N_REQ-1:0]   req_dbl;
  logic [N_REQ-1:0]     req_rot;
  logic [ID_W:0]        idx_sum;

  logic                 pipe_v  [RD_LATENCY];
  logic [ID_W-1:0]      pipe_id [RD_LATENCY];
  logic [MASK_W-1:0]    mask_cnt;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr;
  // the first set bit of the rotated vector, offset back by rr_ptr, wins.
  always_comb begin
    req_dbl = {req_valid, req_valid} >> rr_ptr;
    req_rot = req_dbl[N_REQ-1:0];
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && req_rot[k]) begin
        gnt_any = 1'b1;
        idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (idx_sum >= (ID_W+1)'(N_REQ)) begin
          idx_sum = idx_sum - (ID_W+1)'(N_REQ);
        end
        gnt_idx = idx_sum[ID_W-1:0];
      end
    end
  end

  // The RAM strobe is a pure function of the requests, even during reset;
  // only the handshake back to the requesters is suppressed.
  assign ram_r_req = |req_valid;
  assign rsp_data  = ram_r_data;

  always_comb begin
    ram_r_address = '0;
    req_ready     = '0;
    rsp_valid     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_any && gnt_idx == ID_W'(i)) begin
        ram_r_address = req_addr[i*DEPTH_LOG2 +: DEPTH_LOG2];
        req_ready[i]  = rst_n;
      end
      if (pipe_v[RD_LATENCY-1] && pipe_id[RD_LATENCY-1] == ID_W'(i)) begin
        rsp_valid[i] = rst_n & ram_r_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      mask_cnt <= MASK_W'(RD_LATENCY);
      err_seq  <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_id[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      pipe_v[0]  <= gnt_any;
      pipe_id[0] <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      // The RAM output pipeline is not reset, so whatever it held when
      // reset released must drain before its valid can be trusted.
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - 1'b1;
      end else if (ram_r_valid != pipe_v[RD_LATENCY-1]) begin
        err_seq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fim_dpram_rd_arb.sv
// tb/tb_fim_dpram_rd_arb.sv - self-checking bench for fim_dpram_rd_arb at read latency 1 and 2
`timescale 1ns/1ps
module tb_fim_dpram_rd_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [N*AW-1:0] ADDRS = {5'h1C, 5'h05, 5'h0A, 5'h03};

  typedef struct {
    int              due;
    int              id;
    logic [DW-1:0]   data;
  } exp_t;

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rdy;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;

  logic [N-1:0]  rdy1, rsp1, rdy2, rsp2;
  logic          rreq1, rreq2, rval1, rval2, err1, err2;
  logic [AW-1:0] raddr1, raddr2;
  logic [DW-1:0] rdat1, rdat2, rspd1, rspd2;

  logic          force_rv1 = 1'b0;
  logic          r1_v = 1'b0;
  logic [DW-1:0] r1_d = '0;
  logic [1:0]    r2_v = '0;
  logic [DW-1:0] r2_d0 = '0, r2_d1 = '0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rr_m = 0;
  bit   err_exp1 = 1'b0, err_exp2 = 1'b0;
  exp_t q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fim_dpram_rd_arb #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH_LOG2(AW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy1), .ram_r_req(rreq1), .ram_r_address(raddr1),
    .ram_r_data(rdat1), .ram_r_valid(rval1), .rsp_valid(rsp1), .rsp_data(rspd1),
    .err_seq(err1));

  fim_dpram_rd_arb #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH_LOG2(AW), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy2), .ram_r_req(rreq2), .ram_r_address(raddr2),
    .ram_r_data(rdat2), .ram_r_valid(rval2), .rsp_valid(rsp2), .rsp_data(rspd2),
    .err_seq(err2));

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return ({27'd0, a} * 32'h0001_0203) ^ 32'hC0DE_0000;
  endfunction

  // RAM read ports (no reset, like the real macro)
  always @(posedge clk) begin
    r1_v  <= rreq1;
    r1_d  <= ram_word(raddr1);
    r2_v  <= {r2_v[0], rreq2};
    r2_d0 <= ram_word(raddr2);
    r2_d1 <= r2_d0;
  end
  assign rval1 = r1_v | force_rv1;
  assign rdat1 = r1_d;
  assign rval2 = r2_v[1];
  assign rdat2 = r2_d1;

  function automatic logic [N-1:0] onehot(input int g);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [N*AW-1:0] a, input int i);
    return AW'(a >> (i * AW));
  endfunction

  // Reference arbitration: first valid requester scanning upward from rr, modulo N.
  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    int vi;
    int j;
    vi = int'(v);
    for (int k = 0; k < N; k++) begin
      j = (rr + k) % N;
      if (((vi >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N-1:0] exp_rdy, input string nm);
    int            g;
    exp_t          e;
    logic [AW-1:0] ea;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy == onehot(i)) g = i;
    ea = (g >= 0) ? addr_of(a, g) : '0;
    chk({nm, "_rdy1"}, 64'(rdy1), 64'(exp_rdy));
    chk({nm, "_rdy2"}, 64'(rdy2), 64'(exp_rdy));
    chk({nm, "_addr1"}, 64'(raddr1), 64'(ea));
    chk({nm, "_addr2"}, 64'(raddr2), 64'(ea));
    chk({nm, "_rreq"}, 64'(rreq1), 64'(|v));
    if (g >= 0) begin
      e.id   = g;
      e.data = ram_word(ea);
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 2;
      q2.push_back(e);
      rr_m = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    q1.delete();
    q2.delete();
    rr_m      = 0;
    err_exp1  = 1'b0;
    err_exp2  = 1'b0;
    #1;
    chk("rst_rdy1", 64'(rdy1), 64'(0));
    chk("rst_rdy2", 64'(rdy2), 64'(0));
    chk("rst_rreq1", 64'(rreq1), 64'(1));
    chk("rst_rreq2", 64'(rreq2), 64'(1));
    chk("rst_err1", 64'(err1), 64'(0));
    chk("rst_err2", 64'(err2), 64'(0));
    chk("rst_rsp1", 64'(rsp1), 64'(0));
    chk("rst_rsp2", 64'(rsp2), 64'(0));
    repeat (3) @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  // Response monitor: scoreboard of issued reads, due at a known cycle.
  initial begin : mon
    exp_t e;
    bit   has;
    forever begin
      @(negedge clk);
      #2;
      while (q1.size() > 0 && q1[0].due < cyc) begin
        e = q1.pop_front();
        checks++; failures++;
        $display("FAIL rsp1_lost cycle=%0d got=none want=id%0d", cyc, e.id);
      end
      has = (q1.size() > 0 && q1[0].due == cyc);
      if (has) e = q1.pop_front();
      chk("mon_rsp1", 64'(rsp1), 64'(has ? onehot(e.id) : {N{1'b0}}));
      if (has) chk("mon_data1", 64'(rspd1), 64'(e.data));
      chk("mon_err1", 64'(err1), 64'(err_exp1));
      while (q2.size() > 0 && q2[0].due < cyc) begin
        e = q2.pop_front();
        checks++; failures++;
        $display("FAIL rsp2_lost cycle=%0d got=none want=id%0d", cyc, e.id);
      end
      has = (q2.size() > 0 && q2[0].due == cyc);
      if (has) e = q2.pop_front();
      chk("mon_rsp2", 64'(rsp2), 64'(has ? onehot(e.id) : {N{1'b0}}));
      if (has) chk("mon_data2", 64'(rspd2), 64'(e.data));
      chk("mon_err2", 64'(err2), 64'(err_exp2));
    end
  end

  initial begin : main
    vec_t          tbl[12];
    logic [N-1:0]  v;
    logic [N*AW-1:0] a;

    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0100};
    tbl[2]  = '{4'b0011, 4'b0001};
    tbl[3]  = '{4'b0011, 4'b0010};
    tbl[4]  = '{4'b0000, 4'b0000};
    tbl[5]  = '{4'b1011, 4'b1000};
    tbl[6]  = '{4'b1010, 4'b0010};
    tbl[7]  = '{4'b1111, 4'b0100};
    tbl[8]  = '{4'b1111, 4'b1000};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b1000, 4'b1000};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, ADDRS, tbl[i].rdy, "tbl");
      if (i == 2) begin
        #1;
        chk("single_rsp_lat1", 64'(rsp1), 64'(4'b0100));
        chk("single_data_lat1", 64'(rspd1), 64'(ram_word(5'h05)));
      end
    end

    step('0, ADDRS, '0, "idle");
    step('0, ADDRS, '0, "idle");
    for (int k = 0; k < 8; k++) step(4'b1111, ADDRS, onehot(k % N), "all_valid");

    step(4'b1000, ADDRS, 4'b1000, "b2b_3a");
    step(4'b0001, ADDRS, 4'b0001, "b2b_0");
    step(4'b1000, ADDRS, 4'b1000, "b2b_3b");
    #1;
    chk("b2b_rsp_a", 64'(rsp2), 64'(4'b1000));
    step('0, ADDRS, '0, "idle");
    #1;
    chk("b2b_rsp_b", 64'(rsp2), 64'(4'b0001));
    step('0, ADDRS, '0, "idle");
    #1;
    chk("b2b_rsp_c", 64'(rsp2), 64'(4'b1000));

    step(4'b0010, ADDRS, 4'b0010, "inflight_a");
    step(4'b0100, ADDRS, 4'b0100, "inflight_b");
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    q1.delete();
    q2.delete();
    rr_m      = 0;
    #1;
    chk("midrst_rsp2", 64'(rsp2), 64'(0));
    chk("midrst_rsp1", 64'(rsp1), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step('0, ADDRS, '0, "post_rst_idle");
    step(4'b1111, ADDRS, 4'b0001, "first_after_rst");

    for (int k = 0; k < 400; k++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      a = (N*AW)'($urandom);
      step(v, a, onehot(model_grant(v, rr_m)), "rand");
    end
    for (int k = 0; k < 4; k++) step('0, ADDRS, '0, "drain");

    @(negedge clk);
    force_rv1 = 1'b1;
    #1;
    chk("stray_rsp1", 64'(rsp1), 64'(0));
    @(negedge clk);
    force_rv1 = 1'b0;
    err_exp1  = 1'b1;
    #1;
    chk("stray_err1", 64'(err1), 64'(1));
    for (int k = 0; k < 3; k++) step('0, ADDRS, '0, "err_hold");
    chk("err_sticky", 64'(err1), 64'(1));

    do_reset();
    chk("err_cleared", 64'(err1), 64'(0));
    step(4'b0110, ADDRS, 4'b0010, "lowest_after_rst");
    for (int k = 0; k < 3; k++) step('0, ADDRS, '0, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
